// File: rtl/ghost_collision_ctrl_pkg.sv
// Shared screen geometry, default sizing and FSM state encodings for the
// ghost collision controller.
package ghost_collision_ctrl_pkg;

    localparam int WIDTH_LOG2     = 10;
    localparam int HEIGHT_LOG2    = 9;
    localparam int NUM_GHOSTS_DEF = 4;
    localparam int TILE_DEF       = 20;

    typedef enum logic [1:0] {
        S_PLAY    = 2'd0,
        S_FREEZE  = 2'd1,
        S_RESPAWN = 2'd2,
        S_OVER    = 2'd3
    } state_t;

endpackage

// File: rtl/ghost_collision_ctrl_tile_overlap.sv
// Combinational contact test between the player and one ghost: both axis
// distances must be strictly below one tile.
module ghost_collision_ctrl_tile_overlap
    import ghost_collision_ctrl_pkg::*;
#(
    parameter int TILE = TILE_DEF
)
(
    input  logic [WIDTH_LOG2-1:0]  player_x,
    input  logic [HEIGHT_LOG2-1:0] player_y,
    input  logic [WIDTH_LOG2-1:0]  ghost_x,
    input  logic [HEIGHT_LOG2-1:0] ghost_y,
    output logic                   contact
);

    localparam logic [WIDTH_LOG2-1:0]  TILE_X = WIDTH_LOG2'(TILE);
    localparam logic [HEIGHT_LOG2-1:0] TILE_Y = HEIGHT_LOG2'(TILE);

    logic [WIDTH_LOG2-1:0]  dx_s;
    logic [HEIGHT_LOG2-1:0] dy_s;

    // Larger operand is always the minuend, so the distance never wraps.
    always_comb begin
        if (player_x >= ghost_x) begin
            dx_s = player_x - ghost_x;
        end else begin
            dx_s = ghost_x - player_x;
        end
        if (player_y >= ghost_y) begin
            dy_s = player_y - ghost_y;
        end else begin
            dy_s = ghost_y - player_y;
        end
        contact = (dx_s < TILE_X) && (dy_s < TILE_Y);
    end

endmodule

// File: rtl/ghost_collision_ctrl.sv
// Player/ghost collision controller: registers per-ghost contact, charges one
// life per accepted hit, freezes play, respawns ghosts and latches game-over.
module ghost_collision_ctrl
    import ghost_collision_ctrl_pkg::*;
#(
    parameter int NUM_GHOSTS    = NUM_GHOSTS_DEF,
    parameter int TILE          = TILE_DEF,
    parameter int START_LIVES   = 3,
    parameter int FREEZE_CYCLES = 25_000_000
)
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic [WIDTH_LOG2-1:0]             player_x,
    input  logic [HEIGHT_LOG2-1:0]            player_y,
    input  logic [NUM_GHOSTS*WIDTH_LOG2-1:0]  ghost_x,
    input  logic [NUM_GHOSTS*HEIGHT_LOG2-1:0] ghost_y,
    input  logic                              restart,
    output logic                              hit,
    output logic [$clog2(NUM_GHOSTS)-1:0]     hit_ghost,
    output logic [2:0]                        lives,
    output logic                              freeze,
    output logic                              ghost_reset_n,
    output logic                              game_over
);

    localparam int              CW         = $clog2(FREEZE_CYCLES);
    localparam int              GW         = $clog2(NUM_GHOSTS);
    localparam logic [CW-1:0]   CNT_LOAD   = CW'(FREEZE_CYCLES - 1);
    localparam logic [2:0]      LIVES_INIT = 3'(START_LIVES);

    logic [NUM_GHOSTS-1:0] contact_s;
    logic [NUM_GHOSTS-1:0] contact_r;
    logic [GW-1:0]         first_s;
    state_t                state_r;
    logic [CW-1:0]         cnt_r;

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_overlap
        ghost_collision_ctrl_tile_overlap #(
            .TILE (TILE)
        ) u_overlap (
            .player_x (player_x),
            .player_y (player_y),
            .ghost_x  (ghost_x[g*WIDTH_LOG2 +: WIDTH_LOG2]),
            .ghost_y  (ghost_y[g*HEIGHT_LOG2 +: HEIGHT_LOG2]),
            .contact  (contact_s[g])
        );
    end

    // Registers the contact vector; the FSM only ever looks at this copy.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            contact_r <= {NUM_GHOSTS{1'b0}};
        end else begin
            contact_r <= contact_s;
        end
    end

    // Lowest-index colliding ghost; scanning downwards lets low indices win.
    always_comb begin
        first_s = {GW{1'b0}};
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (contact_r[i]) begin
                first_s = GW'(i);
            end else begin
                first_s = first_s;
            end
        end
    end

    // Game FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_PLAY;
            cnt_r         <= {CW{1'b0}};
            hit           <= 1'b0;
            hit_ghost     <= {GW{1'b0}};
            lives         <= LIVES_INIT;
            freeze        <= 1'b0;
            ghost_reset_n <= 1'b1;
            game_over     <= 1'b0;
        end else begin
            hit <= 1'b0;
            case (state_r)
                S_PLAY: begin
                    freeze        <= 1'b0;
                    ghost_reset_n <= 1'b1;
                    game_over     <= 1'b0;
                    if (|contact_r) begin
                        hit       <= 1'b1;
                        hit_ghost <= first_s;
                        cnt_r     <= CNT_LOAD;
                        freeze    <= 1'b1;
                        // Last life: clamp at zero and stay frozen until restart.
                        if (lives <= 3'd1) begin
                            lives     <= 3'd0;
                            game_over <= 1'b1;
                            state_r   <= S_OVER;
                        end else begin
                            lives   <= lives - 3'd1;
                            state_r <= S_FREEZE;
                        end
                    end else begin
                        state_r <= S_PLAY;
                    end
                end
                S_FREEZE: begin
                    freeze <= 1'b1;
                    if (cnt_r == {CW{1'b0}}) begin
                        ghost_reset_n <= 1'b0;
                        state_r       <= S_RESPAWN;
                    end else begin
                        cnt_r   <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                        state_r <= S_FREEZE;
                    end
                end
                S_RESPAWN: begin
                    freeze        <= 1'b0;
                    ghost_reset_n <= 1'b1;
                    state_r       <= S_PLAY;
                end
                S_OVER: begin
                    if (restart) begin
                        lives         <= LIVES_INIT;
                        ghost_reset_n <= 1'b0;
                        freeze        <= 1'b0;
                        game_over     <= 1'b0;
                        state_r       <= S_PLAY;
                    end else begin
                        freeze    <= 1'b1;
                        game_over <= 1'b1;
                        state_r   <= S_OVER;
                    end
                end
                default: begin
                    freeze        <= 1'b0;
                    ghost_reset_n <= 1'b1;
                    game_over     <= 1'b0;
                    cnt_r         <= {CW{1'b0}};
                    state_r       <= S_PLAY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ghost_collision_ctrl.sv
// Directed and randomized bench for ghost_collision_ctrl against a cycle-timeline
// reference model of lives, freeze windows and respawn pulses.
module tb_ghost_collision_ctrl;
    import ghost_collision_ctrl_pkg::*;

    localparam int NG = 4;
    localparam int TL = 20;
    localparam int SL = 3;
    localparam int FC = 4;

    logic                         clk = 1'b0;
    logic                         reset;
    logic [WIDTH_LOG2-1:0]        player_x;
    logic [HEIGHT_LOG2-1:0]       player_y;
    logic [NG*WIDTH_LOG2-1:0]     ghost_x;
    logic [NG*HEIGHT_LOG2-1:0]    ghost_y;
    logic                         restart;
    logic                         hit;
    logic [1:0]                   hit_ghost;
    logic [2:0]                   lives;
    logic                         freeze;
    logic                         ghost_reset_n;
    logic                         game_over;

    int checks = 0;
    int errors = 0;

    int px, py;
    int gx [NG];
    int gy [NG];
    int home_x [NG] = '{600, 20, 300, 480};
    int home_y [NG] = '{320, 440, 300, 160};

    int          cyc = 0;
    int          m_play_from;
    int          m_rstn_at;
    int          m_lives;
    bit          m_over;
    logic [NG-1:0] m_cq;
    bit          e_hit, e_rstn, e_freeze, e_go;
    int          e_hg;

    ghost_collision_ctrl #(
        .NUM_GHOSTS    (NG),
        .TILE          (TL),
        .START_LIVES   (SL),
        .FREEZE_CYCLES (FC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .player_x      (player_x),
        .player_y      (player_y),
        .ghost_x       (ghost_x),
        .ghost_y       (ghost_y),
        .restart       (restart),
        .hit           (hit),
        .hit_ghost     (hit_ghost),
        .lives         (lives),
        .freeze        (freeze),
        .ghost_reset_n (ghost_reset_n),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        player_x = WIDTH_LOG2'(px);
        player_y = HEIGHT_LOG2'(py);
        for (int i = 0; i < NG; i++) begin
            ghost_x[i*WIDTH_LOG2 +: WIDTH_LOG2]   = WIDTH_LOG2'(gx[i]);
            ghost_y[i*HEIGHT_LOG2 +: HEIGHT_LOG2] = HEIGHT_LOG2'(gy[i]);
        end
    endtask

    task automatic go_home(input int i);
        gx[i] = home_x[i];
        gy[i] = home_y[i];
    endtask

    function automatic logic [NG-1:0] contact_vec();
        logic [NG-1:0] v;
        int dx, dy;
        for (int i = 0; i < NG; i++) begin
            dx = px - gx[i];
            dy = py - gy[i];
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            v[i] = (dx < TL) && (dy < TL);
        end
        return v;
    endfunction

    function automatic int lowest(input logic [NG-1:0] v);
        int r = 0;
        for (int i = NG - 1; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_cq        = '0;
        m_lives     = SL;
        m_over      = 1'b0;
        m_play_from = cyc;
        m_rstn_at   = -1;
        e_hit       = 1'b0;
        e_rstn      = 1'b1;
        e_freeze    = 1'b0;
        e_go        = 1'b0;
        e_hg        = 0;
    endtask

    // Cycle c's outputs: a hit lands two cycles after the contact, only if the
    // previous cycle was a play cycle; a hit blocks play for FC+1 cycles.
    task automatic model_update();
        logic [NG-1:0] prev;
        bit was_play;
        cyc++;
        prev     = m_cq;
        m_cq     = contact_vec();
        was_play = !m_over && (cyc - 1 >= m_play_from);
        e_hit    = 1'b0;
        e_rstn   = 1'b1;
        if (m_over && restart) begin
            m_over      = 1'b0;
            m_lives     = SL;
            m_play_from = cyc;
            e_rstn      = 1'b0;
        end else if (was_play && prev != '0) begin
            e_hit = 1'b1;
            e_hg  = lowest(prev);
            m_lives--;
            if (m_lives == 0) begin
                m_over = 1'b1;
            end else begin
                m_play_from = cyc + FC + 1;
                m_rstn_at   = cyc + FC;
            end
        end
        if (cyc == m_rstn_at) e_rstn = 1'b0;
        e_freeze = m_over || (cyc < m_play_from);
        e_go     = m_over;
    endtask

    task automatic check_all();
        chk("hit", 32'(hit), 32'(e_hit));
        if (e_hit) chk("hit_ghost", 32'(hit_ghost), 32'(e_hg));
        chk("lives", 32'(lives), 32'(m_lives));
        chk("freeze", 32'(freeze), 32'(e_freeze));
        chk("ghost_reset_n", 32'(ghost_reset_n), 32'(e_rstn));
        chk("game_over", 32'(game_over), 32'(e_go));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_hit"}, 32'(hit), 32'd0);
        chk({tag, "_hit_ghost"}, 32'(hit_ghost), 32'd0);
        chk({tag, "_lives"}, 32'(lives), 32'd3);
        chk({tag, "_freeze"}, 32'(freeze), 32'd0);
        chk({tag, "_ghost_reset_n"}, 32'(ghost_reset_n), 32'd1);
        chk({tag, "_game_over"}, 32'(game_over), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    initial begin
        reset   = 1'b0;
        restart = 1'b0;
        px = 100;
        py = 100;
        for (int i = 0; i < NG; i++) go_home(i);
        drive();
        #12;
        check_reset_vals("por");
        model_reset();
        #1 reset = 1'b1;

        // Idle play with every ghost far away.
        for (int k = 0; k < 100; k++) tick();
        chk("idle_lives", 32'(lives), 32'd3);
        chk("idle_freeze", 32'(freeze), 32'd0);
        chk("idle_rstn", 32'(ghost_reset_n), 32'd1);

        // Single hit from ghost 2 and the full freeze/respawn timeline.
        gx[2] = 110; gy[2] = 100; drive();
        tick();
        chk("n1_hit", 32'(hit), 32'd0);
        tick();
        chk("n2_hit", 32'(hit), 32'd1);
        chk("n2_hit_ghost", 32'(hit_ghost), 32'd2);
        chk("n2_lives", 32'(lives), 32'd2);
        chk("n2_freeze", 32'(freeze), 32'd1);
        go_home(2); drive();
        for (int k = 3; k <= 5; k++) begin
            tick();
            chk("n3_5_freeze", 32'(freeze), 32'd1);
            chk("n3_5_rstn", 32'(ghost_reset_n), 32'd1);
        end
        tick();
        chk("n6_rstn", 32'(ghost_reset_n), 32'd0);
        chk("n6_freeze", 32'(freeze), 32'd1);
        tick();
        chk("n7_freeze", 32'(freeze), 32'd0);
        chk("n7_rstn", 32'(ghost_reset_n), 32'd1);

        // Two simultaneous contacts cost one life, lowest index reported.
        gx[1] = 100; gy[1] = 119; gx[3] = 100; gy[3] = 119; drive();
        tick(); tick();
        chk("dual_hit", 32'(hit), 32'd1);
        chk("dual_hit_ghost", 32'(hit_ghost), 32'd1);
        chk("dual_lives", 32'(lives), 32'd1);
        go_home(1); go_home(3); drive();
        for (int k = 0; k < 6; k++) tick();

        // Exactly one tile away is not contact.
        gx[0] = 100; gy[0] = 120; drive();
        for (int k = 0; k < 5; k++) tick();
        chk("edge_lives", 32'(lives), 32'd1);
        chk("edge_freeze", 32'(freeze), 32'd0);

        // Last life: game over, further contact ignored.
        gx[0] = 90; gy[0] = 100; drive();
        tick(); tick();
        chk("over_hit", 32'(hit), 32'd1);
        chk("over_lives", 32'(lives), 32'd0);
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_freeze", 32'(freeze), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        chk("over_hold_lives", 32'(lives), 32'd0);
        go_home(0); drive();
        tick(); tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_lives", 32'(lives), 32'd3);
        chk("restart_rstn", 32'(ghost_reset_n), 32'd0);
        chk("restart_over", 32'(game_over), 32'd0);
        tick();
        chk("restart_next_rstn", 32'(ghost_reset_n), 32'd1);
        chk("restart_next_freeze", 32'(freeze), 32'd0);

        // Asynchronous reset in the middle of a freeze.
        gx[3] = 105; gy[3] = 95; drive();
        tick(); tick(); tick();
        go_home(3); drive();
        #1 reset = 1'b0;
        #1 check_reset_vals("midfrz");
        model_reset();
        #1 reset = 1'b1;
        tick();
        gx[1] = 100; gy[1] = 85; drive();
        tick(); tick();
        chk("post_rst_hit", 32'(hit), 32'd1);
        chk("post_rst_hit_ghost", 32'(hit_ghost), 32'd1);
        chk("post_rst_lives", 32'(lives), 32'd2);
        go_home(1); drive();
        for (int k = 0; k < 8; k++) tick();

        // Randomized play: ghosts occasionally jump next to a wandering player.
        for (int k = 0; k < 600; k++) begin
            px = int'($urandom_range(40, 580));
            py = int'($urandom_range(40, 420));
            for (int i = 0; i < NG; i++) begin
                if ($urandom_range(0, 11) == 0) begin
                    gx[i] = px + int'($urandom_range(0, 50)) - 25;
                    gy[i] = py + int'($urandom_range(0, 50)) - 25;
                end else begin
                    go_home(i);
                end
            end
            restart = ($urandom_range(0, 7) == 0);
            drive();
            tick();
        end
        restart = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
